rcu_pll_lock_ctrl: RTL

// - PLL enable/relock sequencer and lock qualifier on the reference oscillator clock.
// - Sits upstream of the APB4 RCU status logic: drives the PLL reset and config, then

---
 rtl/rcu_pll_lock_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rcu_pll_lock_ctrl.sv
// PLL enable/relock sequencer: drives PLL reset and config, synchronises the raw lock
// and qualifies it over STABLE_CNT cycles before raising pll_lock_o.
module rcu_pll_lock_ctrl #(
    parameter int CFG_WIDTH   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int RST_CYC     = 8,
    parameter int STABLE_CNT  = 64,
    parameter int TIMEOUT_CNT = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pll_en_i,
    input  logic [CFG_WIDTH-1:0] clk_cfg_i,
    input  logic                 clr_i,
    input  logic                 pll_lock_raw_i,
    output logic                 pll_rst_o,
    output logic [CFG_WIDTH-1:0] pll_cfg_o,
    output logic                 pll_lock_o,
    output logic                 lock_lost_o,
    output logic                 timeout_o,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_RESET  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOCKED = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    localparam int RST_W  = (RST_CYC > 1)     ? $clog2(RST_CYC)     : 1;
    localparam int STAB_W = (STABLE_CNT > 1)  ? $clog2(STABLE_CNT)  : 1;
    localparam int TO_W   = (TIMEOUT_CNT > 1) ? $clog2(TIMEOUT_CNT) : 1;

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYC - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CNT - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CNT - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [CFG_WIDTH-1:0]   cfg_q;
    logic                   cfg_chg;
    logic [RST_W-1:0]       rst_cnt;
    logic [STAB_W-1:0]      stab_cnt;
    logic [TO_W-1:0]        to_cnt;
    logic                   rst_entry;
    logic                   set_lost;
    logic                   set_to;
    logic                   in_to_win;
    logic                   nxt_in_to_win;

    assign lock_s  = sync_q[SYNC_STAGES-1];
    assign cfg_chg = (clk_cfg_i != cfg_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!pll_en_i) begin
            state_nxt = ST_OFF;
        end else if (cfg_chg && (state != ST_OFF)) begin
            state_nxt = ST_RESET;
        end else begin
            unique case (state)
                ST_OFF:    state_nxt = ST_RESET;
                ST_RESET:  if (rst_cnt == RST_LAST) state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (lock_s)                 state_nxt = ST_SETTLE;
                    else if (to_cnt == TO_LAST) state_nxt = ST_ERR;
                end
                ST_SETTLE: begin
                    if (!lock_s) state_nxt = (to_cnt == TO_LAST) ? ST_ERR : ST_WAIT;
                    else if (stab_cnt == STAB_LAST) state_nxt = ST_LOCKED;
                end
                ST_LOCKED: if (!lock_s) state_nxt = ST_RESET;
                ST_ERR:    if (clr_i) state_nxt = ST_RESET;
                default:   state_nxt = ST_OFF;
            endcase
        end
    end

    always_comb begin
        pll_rst_o  = 1'b1;
        pll_lock_o = 1'b0;
        unique case (state)
            ST_WAIT, ST_SETTLE: pll_rst_o = 1'b0;
            ST_LOCKED: begin
                pll_rst_o  = 1'b0;
                pll_lock_o = 1'b1;
            end
            default: pll_rst_o = 1'b1;
        endcase
    end

    assign state_o = state;

    // A cfg change while already in RESET counts as a fresh entry (reload cfg, restart count).
    assign rst_entry     = (state_nxt == ST_RESET) && ((state != ST_RESET) || cfg_chg);
    assign in_to_win     = (state == ST_WAIT) || (state == ST_SETTLE);
    assign nxt_in_to_win = (state_nxt == ST_WAIT) || (state_nxt == ST_SETTLE);
    assign set_lost      = (state == ST_LOCKED) && (state_nxt == ST_RESET) && !cfg_chg;
    assign set_to        = (state_nxt == ST_ERR) && (state != ST_ERR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q      <= '0;
            cfg_q       <= '0;
            pll_cfg_o   <= '0;
            rst_cnt     <= '0;
            stab_cnt    <= '0;
            to_cnt      <= '0;
            lock_lost_o <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock_raw_i};
            cfg_q  <= clk_cfg_i;
            if (rst_entry) pll_cfg_o <= clk_cfg_i;

            // Counters saturate rather than wrap and are zero outside their owning states.
            if ((state_nxt == ST_RESET) && !rst_entry)
                rst_cnt <= (rst_cnt == '1) ? rst_cnt : rst_cnt + RST_W'(1);
            else
                rst_cnt <= '0;

            if ((state == ST_SETTLE) && (state_nxt == ST_SETTLE))
                stab_cnt <= (stab_cnt == '1) ? stab_cnt : stab_cnt + STAB_W'(1);
            else
                stab_cnt <= '0;

            if (in_to_win && nxt_in_to_win)
                to_cnt <= (to_cnt == '1) ? to_cnt : to_cnt + TO_W'(1);
            else
                to_cnt <= '0;

            if (set_lost)   lock_lost_o <= 1'b1;
            else if (clr_i) lock_lost_o <= 1'b0;

            if (set_to)     timeout_o <= 1'b1;
            else if (clr_i) timeout_o <= 1'b0;
        end
    end

endmodule
